fbsbdecoder: RTL



---
 rtl/fbsbdecoder_pkg.sv | 39 +++
 rtl/fbsbdecoder_sixbit2fourbit.sv | 21 ++
 rtl/fbsbdecoder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fbsbdecoder_pkg.sv
// Shared 4B6B definitions for the VLC link: codebook, default timing and FSM states.
package fbsbdecoder_pkg;

  localparam int unsigned DefaultBitLength = 50;
  localparam int unsigned DefaultFrameLen  = 23;
  localparam int unsigned SyncBits         = 5;

  typedef enum logic [1:0] {
    StIdle,
    StSyncHi,
    StSyncLo,
    StData
  } state_e;

  // Code bit 0 goes on the line first.
  function automatic logic [5:0] four_to_six(input logic [3:0] nibble);
    logic [5:0] code;
    unique case (nibble)
      4'h0: code = 6'b001110;
      4'h1: code = 6'b001101;
      4'h2: code = 6'b010011;
      4'h3: code = 6'b010110;
      4'h4: code = 6'b010101;
      4'h5: code = 6'b100011;
      4'h6: code = 6'b100110;
      4'h7: code = 6'b100101;
      4'h8: code = 6'b011001;
      4'h9: code = 6'b011010;
      4'hA: code = 6'b011100;
      4'hB: code = 6'b110001;
      4'hC: code = 6'b110010;
      4'hD: code = 6'b101001;
      4'hE: code = 6'b101010;
      4'hF: code = 6'b101100;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fbsbdecoder_sixbit2fourbit.sv
// sixBit2fourBit: inverse 4B6B lookup; valid drops for any code outside the codebook.
module fbsbdecoder_sixbit2fourbit
  import fbsbdecoder_pkg::*;
(
  input  logic [5:0] code,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (four_to_six(4'(i)) == code) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fbsbdecoder.sv
// Receive-side 4B6B decoder: sync preamble detection, mid-bit sampling with edge re-centring,
// and symbol-to-byte decoding with frame-end and code-error pulses.
module fbsbdecoder
  import fbsbdecoder_pkg::*;
#(
  parameter int unsigned BitLength = DefaultBitLength,
  parameter int unsigned FrameLen  = DefaultFrameLen,
  parameter int unsigned SyncTol   = 25
) (
  input  logic       pclk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_done,
  output logic       code_error,
  output logic       decoding
);

  localparam logic [15:0] SyncMin     = 16'(SyncBits * BitLength - SyncTol);
  localparam logic [15:0] SyncMax     = 16'(SyncBits * BitLength + SyncTol);
  localparam logic [15:0] FirstSample = 16'(SyncBits * BitLength + BitLength / 2 - 1);
  localparam logic [15:0] SamplePhase = 16'(BitLength / 2 - 1);
  localparam logic [15:0] PhaseMax    = 16'(BitLength - 1);
  localparam logic [15:0] PhasePost   = 16'(BitLength / 2);
  localparam logic [7:0]  LastSym     = 8'(FrameLen);

  logic        rx_meta, rx_s, rx_d;
  logic        rx_rise, rx_fall, rx_edge;
  state_e      state_q;
  logic [15:0] cnt_q;
  logic [3:0]  bit_idx_q;
  logic [7:0]  sym_cnt_q;
  logic [11:0] shreg_q;
  logic [11:0] shift_next;
  logic [3:0]  lo_nib, hi_nib;
  logic        lo_ok, hi_ok;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      rx_d    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign rx_rise    = rx_s & ~rx_d;
  assign rx_fall    = ~rx_s & rx_d;
  assign rx_edge    = rx_s ^ rx_d;
  assign shift_next = {rx_s, shreg_q[11:1]};

  // Decoders see the register contents including the sample being taken this cycle.
  fbsbdecoder_sixbit2fourbit u_dec_lo (
    .code   (shift_next[5:0]),
    .nibble (lo_nib),
    .valid  (lo_ok)
  );

  fbsbdecoder_sixbit2fourbit u_dec_hi (
    .code   (shift_next[11:6]),
    .nibble (hi_nib),
    .valid  (hi_ok)
  );

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      sym_cnt_q  <= '0;
      shreg_q    <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      code_error <= 1'b0;
      decoding   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      code_error <= 1'b0;
      decoding   <= (state_q != StIdle);

      unique case (state_q)
        StIdle: begin
          sym_cnt_q <= '0;
          bit_idx_q <= '0;
          // decoding still high marks the first IDLE cycle; an edge there is ignored.
          if (rx_rise && !decoding) begin
            cnt_q   <= '0;
            state_q <= StSyncHi;
          end
        end

        StSyncHi: begin
          if (rx_fall) begin
            if (cnt_q >= SyncMin && cnt_q <= SyncMax) begin
              cnt_q   <= '0;
              state_q <= StSyncLo;
            end else begin
              state_q <= StIdle;
            end
          end else if (cnt_q > SyncMax) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StSyncLo: begin
          if (rx_rise && cnt_q < SyncMin) begin
            state_q <= StIdle;
          end else if (cnt_q == FirstSample) begin
            // Centre of data bit 0; phase continues so the next sample lands one bit later.
            shreg_q   <= shift_next;
            bit_idx_q <= 4'd1;
            cnt_q     <= PhasePost;
            state_q   <= StData;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StData: begin
          if (rx_edge || cnt_q >= PhaseMax) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end

          if (cnt_q == SamplePhase) begin
            shreg_q <= shift_next;
            if (bit_idx_q == 4'd11) begin
              bit_idx_q <= '0;
              if (lo_ok && hi_ok) begin
                data_out   <= {hi_nib, lo_nib};
                data_valid <= 1'b1;
                if (sym_cnt_q == LastSym) begin
                  frame_done <= 1'b1;
                  sym_cnt_q  <= '0;
                  state_q    <= StIdle;
                end else begin
                  sym_cnt_q <= sym_cnt_q + 8'd1;
                end
              end else if (shift_next == '0 && sym_cnt_q != '0) begin
                // Transmitter stopped early: an all-zero symbol ends the frame cleanly.
                frame_done <= 1'b1;
                sym_cnt_q  <= '0;
                state_q    <= StIdle;
              end else begin
                code_error <= 1'b1;
                sym_cnt_q  <= '0;
                state_q    <= StIdle;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
